// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive buffer that sits directly behind the UART receiver. Each word the
//   receiver strobes out with data_ready is stored together with its parity
//   and frame error flags. Entries are presented first-word-fall-through to
//   the consumer over a valid/ready handshake.
//
// Parameters
//   DATA_BITS    received word width (1..15)
//   DEPTH        number of entries, power of two (2..256)
//   AFULL_LEVEL  almost_full threshold, asserted when level >= AFULL_LEVEL
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   rx_data, parity_err,
//   frame_err            word and flags from the receiver
//   data_ready           one-cycle strobe qualifying the receiver outputs
//   rd_data, rd_parity_err,
//   rd_frame_err         head entry (combinational from storage)
//   rd_valid             head entry present
//   rd_ready             consumer takes the head entry this cycle
//   level                entry count, 0..DEPTH
//   full, almost_full    fill status derived from the registered count
//   overrun              sticky: a word arrived while full and was dropped
//   clear_overrun        clears overrun (a coincident new overrun wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 14
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_BITS-1:0]       rx_data,
    input  logic                       data_ready,
    input  logic                       parity_err,
    input  logic                       frame_err,
    output logic [DATA_BITS-1:0]       rd_data,
    output logic                       rd_parity_err,
    output logic                       rd_frame_err,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       almost_full,
    output logic                       overrun,
    input  logic                       clear_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_BITS + 2;

    // Entry layout: {frame_err, parity_err, rx_data}
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    logic          push;
    logic          pop;
    logic          is_full;
    logic          drop;

    assign is_full  = (count == LW'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = data_ready & (~is_full | pop);
    assign drop     = data_ready & is_full & ~pop;

    // Storage and pointers. Pointers are AW bits so they wrap on their own;
    // the separate count disambiguates full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {frame_err, parity_err, rx_data};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Set has priority over clear so a drop is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           overrun <= 1'b0;
        else if (drop)          overrun <= 1'b1;
        else if (clear_overrun) overrun <= 1'b0;
    end

    assign {rd_frame_err, rd_parity_err, rd_data} = mem[rd_ptr];

    assign level       = count;
    assign full        = is_full;
    assign almost_full = (count >= LW'(AFULL_LEVEL));

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DB    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DB-1:0] rx_data = '0;
    logic          data_ready = 1'b0;
    logic          parity_err = 1'b0;
    logic          frame_err = 1'b0;
    logic [DB-1:0] rd_data;
    logic          rd_parity_err;
    logic          rd_frame_err;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [4:0]    level;
    logic          full;
    logic          almost_full;
    logic          overrun;
    logic          clear_overrun = 1'b0;

    uart_rx_fifo #(.DATA_BITS(DB), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .data_ready(data_ready),
        .parity_err(parity_err), .frame_err(frame_err),
        .rd_data(rd_data), .rd_parity_err(rd_parity_err), .rd_frame_err(rd_frame_err),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .level(level), .full(full), .almost_full(almost_full),
        .overrun(overrun), .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Scoreboard: {frame_err, parity_err, data} in arrival order
    logic [DB+1:0] q[$];
    bit            m_ov = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state();
        chk("rd_valid", rd_valid, q.size() != 0);
        chk("level", level, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("almost_full", almost_full, q.size() >= AFL);
        chk("overrun", overrun, m_ov);
        if (q.size() != 0)
            chk("head", {rd_frame_err, rd_parity_err, rd_data}, q[0]);
    endtask

    // One clock: drive inputs, predict, advance, compare against the model.
    task automatic cyc(input bit dr, input logic [DB-1:0] d, input bit pe,
                       input bit fe, input bit rdy, input bit clr);
        bit pop, push, drop;
        data_ready = dr; rx_data = d; parity_err = pe; frame_err = fe;
        rd_ready = rdy; clear_overrun = clr;
        pop  = rdy && q.size() != 0;
        push = dr && (q.size() < DEPTH || pop);
        drop = dr && q.size() == DEPTH && !pop;
        if (pop) chk("pop_data", {rd_frame_err, rd_parity_err, rd_data}, q[0]);
        @(posedge clk); #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back({fe, pe, d});
        if (drop) m_ov = 1'b1;
        else if (clr) m_ov = 1'b0;
        data_ready = 1'b0; rd_ready = 1'b0; clear_overrun = 1'b0;
        chk_state();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_data"}, {rd_frame_err, rd_parity_err, rd_data}, 0);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #2;
        check_reset_outputs(tag);  // asynchronous: no clock edge needed
        q.delete();
        m_ov = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, DB'(base + i), i[0], i[1], 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    typedef struct {
        bit            dr;
        logic [DB-1:0] d;
        bit            pe, fe, rdy, clr;
        bit            ev;
        int            el;
        bit            cd;      // compare data even when not valid
        logic [DB-1:0] ed;
        bit            epe, efe;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{dr:0, d:8'h00, pe:0, fe:0, rdy:0, clr:0, ev:0, el:0, cd:1, ed:8'h00, epe:0, efe:0};
        vt[1] = '{dr:1, d:8'h5A, pe:1, fe:0, rdy:0, clr:0, ev:1, el:1, cd:1, ed:8'h5A, epe:1, efe:0};
        vt[2] = '{dr:0, d:8'h00, pe:0, fe:0, rdy:1, clr:0, ev:0, el:0, cd:0, ed:8'h00, epe:0, efe:0};
        // empty + strobe + rd_ready: write only
        vt[3] = '{dr:1, d:8'h3C, pe:0, fe:1, rdy:1, clr:0, ev:1, el:1, cd:1, ed:8'h3C, epe:0, efe:1};
        vt[4] = '{dr:0, d:8'h00, pe:0, fe:0, rdy:0, clr:0, ev:1, el:1, cd:1, ed:8'h3C, epe:0, efe:1};
        vt[5] = '{dr:0, d:8'h00, pe:0, fe:0, rdy:1, clr:0, ev:0, el:0, cd:0, ed:8'h00, epe:0, efe:0};

        do_reset("rst");

        for (int i = 0; i < 6; i++) begin
            cyc(vt[i].dr, vt[i].d, vt[i].pe, vt[i].fe, vt[i].rdy, vt[i].clr);
            chk($sformatf("vec%0d_valid", i), rd_valid, vt[i].ev);
            chk($sformatf("vec%0d_level", i), level, vt[i].el);
            if (vt[i].cd) begin
                chk($sformatf("vec%0d_data", i), rd_data, vt[i].ed);
                chk($sformatf("vec%0d_pe", i), rd_parity_err, vt[i].epe);
                chk($sformatf("vec%0d_fe", i), rd_frame_err, vt[i].efe);
            end
        end

        // Fill to DEPTH, check thresholds, then over-drain.
        fill(0);
        chk("fill_full", full, 1);
        chk("fill_afull", almost_full, 1);
        drain(20);
        chk("drain_valid", rd_valid, 0);

        // Overrun: dropped word, set-wins-over-clear, then clear.
        fill(0);
        cyc(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovr_set", overrun, 1);
        chk("ovr_level", level, DEPTH);
        cyc(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_set_wins", overrun, 1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_sticky", overrun, 1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_clear", overrun, 0);
        drain(17);

        // Full + strobe + pop in the same cycle.
        fill(0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fp_ovr", overrun, 0);
        chk("fp_level", level, DEPTH);
        chk("fp_head", rd_data, 8'h01);
        drain(15);
        chk("fp_last", rd_data, 8'hBB);
        drain(1);
        chk("fp_empty", rd_valid, 0);

        // Interleaved traffic: pointers wrap more than twice.
        for (int i = 0; i < 40; i++)
            cyc(1'b1, DB'(i * 7 + 3), i[0], i[2], (i % 3) != 0, 1'b0);
        drain(DEPTH + 2);

        // Mid-stream asynchronous reset.
        for (int i = 0; i < 5; i++) cyc(1'b1, DB'(8'hC0 + i), 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset("mid");
        cyc(1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("post_rst_data", rd_data, 8'h77);
        chk("post_rst_level", level, 1);
        drain(1);
        chk("post_rst_empty", rd_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer directly downstream of the UART receiver.
- Captures each received word together with its parity and frame error flags on the receiver's single-cycle data_ready strobe.
- Holds up to DEPTH entries and presents them first-word-fall-through to the consumer over a valid/ready handshake.
- Reports fill level, almost-full, and a sticky overrun flag.

Parameters:
DATA_BITS, 8, width of received data word; matches receiver DATA_BITS (1..15)
DEPTH, 16, number of entries; power of two, 2..256
AFULL_LEVEL, 14, almost_full asserts when level >= AFULL_LEVEL (1..DEPTH)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
rx_data  input  DATA_BITS  received word from receiver
data_ready  input  1  one-cycle strobe: rx_data/parity_err/frame_err valid this cycle
parity_err  input  1  parity error flag for this word
frame_err  input  1  frame (stop bit) error flag for this word
rd_data  output  DATA_BITS  head entry data
rd_parity_err  output  1  head entry parity flag
rd_frame_err  output  1  head entry frame flag
rd_valid  output  1  head entry present (FIFO not empty)
rd_ready  input  1  consumer accepts head this cycle
level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH
full  output  1  level == DEPTH
almost_full  output  1  level >= AFULL_LEVEL
overrun  output  1  sticky: a strobe arrived while full and was dropped
clear_overrun  input  1  clears overrun

Behaviour:
- Reset (reset_n low, asynchronous):
  - write/read pointers, count and overrun all 0.
  - Storage cleared to 0.
  - Resulting outputs: rd_valid=0, rd_data=0, rd_parity_err=0, rd_frame_err=0, level=0, full=0, almost_full=0.
  - Reset mid-operation discards all contents; first write after release lands in entry 0.
- Entry format: {frame_err, parity_err, rx_data}, DATA_BITS+2 bits, stored unmodified. Error flags do not block storage.
- Push: data_ready=1 and (not full, or pop in the same cycle). Entry written at wr_ptr on the clk edge; wr_ptr increments modulo DEPTH.
- Pop: rd_valid=1 and rd_ready=1. rd_ptr increments modulo DEPTH. rd_ready while rd_valid=0 has no effect.
- FWFT read path:
  - rd_data/rd_parity_err/rd_frame_err are driven combinationally from storage[rd_ptr].
  - A push into an empty FIFO makes rd_valid=1 on the cycle after the strobe, with that entry on rd_data.
  - When rd_valid=0, rd_* data outputs show storage[rd_ptr] (stale); the bench does not check them.
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- level, full and almost_full are registered-state derived and update in the cycle after the causing edge.
- Full + strobe + pop in the same cycle: both occur, level stays DEPTH, no overrun.
- Empty + strobe + rd_ready: no pop (rd_valid=0), write only, level becomes 1.
- Overrun:
  - Trigger: data_ready=1, full=1, no pop. The incoming word is dropped, contents are unchanged, and overrun is set next cycle.
  - overrun stays set until clear_overrun=1.
  - If a new overrun and clear_overrun coincide, set wins (overrun remains 1).
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Count is tracked separately, so full and empty are unambiguous.
- Single clock domain; data_ready is already synchronous to clk. No internal synchronisers.

Test Plan:
- Reset then idle → rd_valid=0, level=0, full=0, almost_full=0, overrun=0, rd_data=0.
- Strobe 0x5A with parity_err=1, rd_ready=0 → next cycle rd_valid=1, rd_data=0x5A, rd_parity_err=1, rd_frame_err=0, level=1. Assert rd_ready one cycle → rd_valid=0, level=0.
- 16 strobes 0x00..0x0F, no reads:
  - level reaches 14 → almost_full=1.
  - level reaches 16 → full=1.
  - Then 20 pops → data 0x00..0x0F in order, rd_valid drops after the 16th pop, extra rd_ready ignored.
- Fill to 16, strobe 0xAA with rd_ready=0 → overrun=1, level=16, later pops return 0x00..0x0F (0xAA absent). Pulse clear_overrun → overrun=0.
- Fill to 16, strobe 0xBB with rd_ready=1 same cycle → no overrun, level=16, head becomes 0x01; after 15 further pops, last entry read is 0xBB.
- 40 pushes interleaved with pops so pointers wrap twice → all 40 words read back in order with matching flags; level never exceeds DEPTH. Assert reset_n low mid-stream → all outputs return to reset values immediately, and the next strobe is read back as the sole entry.
